// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select codes, SREG bit positions and sequencer state encoding.
// Imported by the wide sequencer and by anything that drives the byte ALU.
package alu_pkg;

    localparam logic [3:0] FSL_ADD     = 4'h0;
    localparam logic [3:0] FSL_SUB     = 4'h1;
    localparam logic [3:0] FSL_ADDC    = 4'h2;
    localparam logic [3:0] FSL_SUBC    = 4'h3;
    localparam logic [3:0] FSL_XOR     = 4'h4;
    localparam logic [3:0] FSL_AND     = 4'h5;
    localparam logic [3:0] FSL_OR      = 4'h6;
    localparam logic [3:0] FSL_NAND    = 4'h7;
    localparam logic [3:0] FSL_NOR     = 4'h8;
    localparam logic [3:0] FSL_XNOR    = 4'h9;
    localparam logic [3:0] FSL_SHL     = 4'hA;
    localparam logic [3:0] FSL_SHR     = 4'hB;
    localparam logic [3:0] FSL_ROL     = 4'hC;
    localparam logic [3:0] FSL_ROR     = 4'hD;
    localparam logic [3:0] FSL_PASSB   = 4'hE;
    localparam logic [3:0] FSL_COMPARE = 4'hF;

    localparam int SREG_ZERO  = 0;
    localparam int SREG_CARRY = 1;
    localparam int SREG_SIGN  = 2;
    localparam int SREG_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == FSL_ADD) || (op == FSL_SUB);
    endfunction

    function automatic logic op_is_supported(input logic [3:0] op);
        return op_is_arith(op) || (op == FSL_XOR) || (op == FSL_AND) ||
               (op == FSL_OR) || (op == FSL_NAND);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Runs NBYTES-wide add/sub/bitwise ops through the shared 8-bit ALU, one byte per cycle LSB first.
// Latency NBYTES+1 cycles accept-to-out_valid; accepts only in IDLE, result held until out_ready.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_op,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_result,
    output logic [3:0]          out_sreg,
    output logic                out_err,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_fsl,
    output logic                alu_cin,
    input  logic [7:0]          alu_result,
    input  logic [3:0]          alu_sreg
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    seq_state_t      r_state;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic            r_zacc;
    logic [W-1:0]    r_result;
    logic [3:0]      r_sreg;
    logic            r_err;

    logic            w_run;
    logic            w_first;
    logic            w_last;
    logic            w_arith;
    logic            w_unused_sreg;

    assign w_run   = (r_state == ST_RUN);
    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == LAST_IDX);
    assign w_arith = op_is_arith(r_op);

    // The ALU's own zero/sign flags only describe one byte; wide versions are rebuilt here.
    assign w_unused_sreg = alu_sreg[SREG_ZERO] ^ alu_sreg[SREG_SIGN];

    assign in_ready   = (r_state == ST_IDLE) && !reset;
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign out_sreg   = r_sreg;
    assign out_err    = r_err;

    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_fsl = FSL_ADD;
        alu_cin = 1'b0;
        if (w_run) begin
            alu_a = r_a[r_idx*8 +: 8];
            alu_b = r_b[r_idx*8 +: 8];
            case (r_op)
                FSL_ADD: begin
                    alu_fsl = w_first ? FSL_ADD : FSL_ADDC;
                    alu_cin = w_first ? 1'b0 : r_carry;
                end
                FSL_SUB: begin
                    alu_fsl = w_first ? FSL_SUB : FSL_SUBC;
                    alu_cin = w_first ? 1'b0 : r_carry;
                end
                default: alu_fsl = r_op;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_op     <= FSL_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b1;
            r_result <= '0;
            r_sreg   <= 4'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op     <= in_op;
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_zacc   <= 1'b1;
                        r_result <= '0;
                        r_sreg   <= 4'h0;
                        if (op_is_supported(in_op)) begin
                            r_err   <= 1'b0;
                            r_state <= ST_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    r_result[r_idx*8 +: 8] <= alu_result;
                    r_carry <= alu_sreg[SREG_CARRY];
                    r_zacc  <= r_zacc & (alu_result == 8'h00);
                    if (w_last) begin
                        // Top byte sets the wide flags; bitwise ops never report carry/overflow.
                        r_sreg[SREG_ZERO]  <= r_zacc & (alu_result == 8'h00);
                        r_sreg[SREG_CARRY] <= w_arith & alu_sreg[SREG_CARRY];
                        r_sreg[SREG_SIGN]  <= alu_result[7];
                        r_sreg[SREG_OVF]   <= w_arith & alu_sreg[SREG_OVF];
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer (NBYTES=2) with a behavioural byte ALU attached to its ALU ports.
module tb_alu_wide_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_sreg;
    logic          out_err;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_fsl;
    logic          alu_cin;
    logic [7:0]    alu_result;
    logic [3:0]    alu_sreg;

    alu_wide_sequencer #(.NBYTES(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sreg   (out_sreg),
        .out_err    (out_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fsl    (alu_fsl),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_sreg   (alu_sreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference byte ALU: sreg = {OVF, SIGN, CARRY/BORROW, ZERO}.
    function automatic logic [11:0] alu_model(input logic [3:0] fsl, input logic [7:0] a,
                                               input logic [7:0] b, input logic cin);
        logic [8:0] t;
        logic [7:0] r;
        logic       c;
        logic       v;
        t = 9'h000;
        c = 1'b0;
        v = 1'b0;
        case (fsl)
            4'h0: t = {1'b0, a} + {1'b0, b};
            4'h1: t = {1'b0, a} - {1'b0, b};
            4'h2: t = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            4'h3: t = {1'b0, a} - {1'b0, b} - {8'h00, cin};
            4'h4: t = {1'b0, a ^ b};
            4'h5: t = {1'b0, a & b};
            4'h6: t = {1'b0, a | b};
            4'h7: t = {1'b0, ~(a & b)};
            default: t = 9'h000;
        endcase
        r = t[7:0];
        if (fsl <= 4'h3) c = t[8];
        if (fsl == 4'h0 || fsl == 4'h2) v = (a[7] == b[7]) && (r[7] != a[7]);
        if (fsl == 4'h1 || fsl == 4'h3) v = (a[7] != b[7]) && (r[7] != a[7]);
        return {v, r[7], c, (r == 8'h00), r};
    endfunction

    always_comb {alu_sreg, alu_result} = alu_model(alu_fsl, alu_a, alu_b, alu_cin);

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   sreg;
        logic         err;
        logic [3:0]   fsl0;
        logic [3:0]   fsl1;
        logic         cin1;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   sreg;
        logic         err;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drives a request and returns just after the accepting edge; pushes its expectation.
    task automatic send(input vec_t v, input bit keep);
        int n;
        exp_t e;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.res  = v.res;
        e.sreg = v.sreg;
        e.err  = v.err;
        sb.push_back(e);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Waits for out_valid, records byte issues, scores, holds, then releases the result.
    task automatic collect(input vec_t v, input int hold);
        int   cyc;
        logic [3:0] f0, f1;
        logic c0, c1;
        exp_t e;
        logic [W-1:0] held;
        cyc = 0;
        f0 = 4'hX; f1 = 4'hX; c0 = 1'bX; c1 = 1'bX;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin f0 = alu_fsl; c0 = alu_cin; end
            if (cyc == 2) begin f1 = alu_fsl; c1 = alu_cin; end
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(cyc), v.err ? 32'd1 : 32'(NB + 1));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("result", 32'(out_result), 32'(e.res));
            check("sreg", 32'(out_sreg), 32'(e.sreg));
            check("err", 32'(out_err), 32'(e.err));
        end
        if (!v.err) begin
            check("fsl_byte0", 32'(f0), 32'(v.fsl0));
            check("cin_byte0", 32'(c0), 32'd0);
            check("fsl_byte1", 32'(f1), 32'(v.fsl1));
            check("cin_byte1", 32'(c1), 32'(v.cin1));
        end
        held = out_result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_no_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(out_result), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("idle_result_stable", 32'(out_result), 32'(held));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op    a        b        res      sreg  err   f0    f1    c1
        vecs[0]  = '{4'h0, 16'h00FF, 16'h0001, 16'h0100, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1};
        vecs[1]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'h3, 1'b0, 4'h0, 4'h2, 1'b1};
        vecs[2]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'hC, 1'b0, 4'h0, 4'h2, 1'b1};
        vecs[3]  = '{4'h1, 16'h1234, 16'h1234, 16'h0000, 4'h1, 1'b0, 4'h1, 4'h3, 1'b0};
        vecs[4]  = '{4'h1, 16'h0100, 16'h0001, 16'h00FF, 4'h0, 1'b0, 4'h1, 4'h3, 1'b1};
        vecs[5]  = '{4'h4, 16'hA5A5, 16'hFFFF, 16'h5A5A, 4'h0, 1'b0, 4'h4, 4'h4, 1'b0};
        vecs[6]  = '{4'h8, 16'h1234, 16'h5678, 16'h0000, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{4'h5, 16'hF0F0, 16'h8F0F, 16'h8000, 4'h4, 1'b0, 4'h5, 4'h5, 1'b0};
        vecs[8]  = '{4'h6, 16'h0000, 16'h0000, 16'h0000, 4'h1, 1'b0, 4'h6, 4'h6, 1'b0};
        vecs[9]  = '{4'h7, 16'h00FF, 16'hFF00, 16'hFFFF, 4'h4, 1'b0, 4'h7, 4'h7, 1'b0};
        vecs[10] = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 4'h6, 1'b0, 4'h1, 4'h3, 1'b1};
        vecs[11] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0};
        vecs[12] = '{4'h0, 16'h8000, 16'h8000, 16'h0000, 4'hB, 1'b0, 4'h0, 4'h2, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_sreg", 32'(out_sreg), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_alu_drive", 32'({alu_a, alu_b, alu_fsl, alu_cin}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i], 1'b0);
            collect(vecs[i], 0);
        end

        // Request kept valid while the result is stalled: no second accept until IDLE.
        send(vecs[5], 1'b1);
        collect(vecs[5], 5);
        check("no_accept_in_done_exit", 32'(in_ready), 32'd1);
        begin
            exp_t e;
            e.res = vecs[5].res; e.sreg = vecs[5].sreg; e.err = vecs[5].err;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect(vecs[5], 0);

        // Reset while byte 1 is on the ALU abandons the operation.
        send(vecs[1], 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_fsl_byte1", 32'(alu_fsl), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_sreg", 32'(out_sreg), 32'd0);
        check("mid_rst_err", 32'(out_err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_alu_fsl", 32'(alu_fsl), 32'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        send(vecs[2], 1'b0);
        collect(vecs[2], 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
